baccarat_fsm: RTL and testbench
===============================

// Module: baccarat_fsm
// PURPOSE
// Control FSM for one Baccarat hand. It sits directly upstream of the card datapath and drives its six
// load_* enables, one card per slow_clock edge. It consumes the datapath's combinational player/dealer
// scores and the player's third card, applies the drawing rules, and lights the winner at end of hand.
// PARAMETERS
// CARD_W   4  width of card code (0=empty, 1=A, 2..10, 11..13=J/Q/K; 14,15 illegal)
// SCORE_W  4  width of score inputs (legal range 0..9)
// PORTS
// slow_clock        in   1        single clock; all state updates on rising edge
// reset             in   1        asynchronous, active-high; restarts the hand
// pscore_in         in   SCORE_W  player hand score from datapath, valid the cycle after its load
// dscore_in         in   SCORE_W  dealer hand score from datapath, same timing
// pcard3_in         in   CARD_W   player third card code from datapath
// load_pcard1..3    out  1 each   datapath load enables; datapath captures new card on next edge
// load_dcard1..3    out  1 each   as above, dealer
// player_win_light  out  1        player wins (both lights on a tie)
// dealer_win_light  out  1        dealer wins (both lights on a tie)
// hand_done         out  1        high while in DONE
// state_out         out  4        current state encoding, for debug/HEX display
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high. Top level drives datapath reset from same source.
// - Reset: state=START(0); all outputs 0 immediately, independent of clock. Reset mid-hand aborts at once.
// - All outputs Moore-decoded from state register; exactly one load_* high in each DEAL_* state, else none.
// - States/encodings, transitions on each rising edge:
//   START(0)->DEAL_P1(1)->DEAL_D1(2)->DEAL_P2(3)->DEAL_D2(4)->CHECK(5).
//   CHECK: scores reflect 4 cards. pscore>=8 or dscore>=8 (natural) -> DONE(9).
//     else pscore<=5 -> DEAL_P3(6); else (6/7) dscore<=5 -> DEAL_D3(8); else -> DONE.
//   DEAL_P3 (load_pcard3) -> BANKER(7).
//   BANKER: v = player 3rd-card value = pcard3_in if 1..9, else 0 (10..15 and 0 map to 0). Draw iff:
//     dscore 0..2 always; 3: v!=8; 4: v in 2..7; 5: v in 4..7; 6: v in 6..7; 7..9: never.
//     draw -> DEAL_D3, else -> DONE.
//   DEAL_D3 (load_dcard3) -> DONE.
//   DONE: absorbing until reset; hand_done=1.
//   Encodings 10..15 unreachable; if entered -> START next edge.
// - Lights (valid only in DONE, 0 in every other state): combinational compare in DONE:
//   pscore>dscore -> player only; dscore>pscore -> dealer only; equal -> both.
//   Scores are final in DONE because the last load lands on the edge entering DONE.
// - Decisions in CHECK/BANKER use inputs sampled that cycle; scores out of range (>9) are treated as 9.
// - Hand length: 6 edges (natural or both stand), 8 (player draws, banker stands), 9 (both draw).
//   Dealer-only draw (player stands) takes 7 edges.
// - No handshake with datapath: the datapath must capture on every edge at which a load_* is high.
// TESTING (bench models datapath: registers + mod-10 scoring, drives scores back)
// 1. assert reset in any state -> all outputs 0 same cycle, state_out=0.
//    Release -> loads P1,D1,P2,D2 on edges 1..4, one-hot.
// 2. cards P=4,4 D=3,K -> CHECK sees p=8,d=3 -> DONE next edge; player_win=1, dealer_win=0; no 3rd loads.
// 3. P=2,2 D=3,K; pcard3=8 -> load_pcard3; BANKER v=8,d=3 -> no load_dcard3.
//    Final p=2,d=3 -> dealer only.
// 4. P=3,4 (7) D=2,3 (5) -> skip DEAL_P3, load_dcard3 once; dcard3=A gives d=6 -> player wins.
// 5. P=A,5 D=4,2; pcard3=Q (v=0) -> d=6, no dealer draw; p=6 -> tie, both lights on.
// 6. reset pulse in DEAL_P3 and in DONE -> outputs 0 asynchronously; after release, full sequence restarts from START.

Source files
------------

// File: rtl/baccarat_fsm_if.sv
// baccarat_fsm_if: FSM <-> card datapath bundle.
// master (FSM): takes scores and player third card, drives load enables, lights, hand_done, state_out.
// slave (datapath): the mirror image.
interface baccarat_fsm_if #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
);
  logic [SCORE_W-1:0] pscore_in;
  logic [SCORE_W-1:0] dscore_in;
  logic [CARD_W-1:0]  pcard3_in;
  logic               load_pcard1;
  logic               load_pcard2;
  logic               load_pcard3;
  logic               load_dcard1;
  logic               load_dcard2;
  logic               load_dcard3;
  logic               player_win_light;
  logic               dealer_win_light;
  logic               hand_done;
  logic [3:0]         state_out;
  modport master (
    input  pscore_in, dscore_in, pcard3_in,
    output load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, hand_done, state_out
  );
  modport slave (
    output pscore_in, dscore_in, pcard3_in,
    input  load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, hand_done, state_out
  );
endinterface

// File: rtl/baccarat_fsm.sv
// baccarat_fsm: control FSM for one Baccarat hand, one card load per slow_clock edge.
// slow_clock/reset (async, active-high) plain ports; bus carries scores, pcard3, six load enables,
// win lights, hand_done and state_out. All outputs are decoded from the state register.
module baccarat_fsm (
  input logic            slow_clock,
  input logic            reset,
  baccarat_fsm_if.master bus
);
  localparam logic [3:0] START   = 4'd0;
  localparam logic [3:0] DEAL_P1 = 4'd1;
  localparam logic [3:0] DEAL_D1 = 4'd2;
  localparam logic [3:0] DEAL_P2 = 4'd3;
  localparam logic [3:0] DEAL_D2 = 4'd4;
  localparam logic [3:0] CHECK   = 4'd5;
  localparam logic [3:0] DEAL_P3 = 4'd6;
  localparam logic [3:0] BANKER  = 4'd7;
  localparam logic [3:0] DEAL_D3 = 4'd8;
  localparam logic [3:0] DONE    = 4'd9;

  logic [3:0] state, nxt, ps, ds, v;
  logic       natural, draw;

  always_comb begin
    ps = (bus.pscore_in > 4'd9) ? 4'd9 : bus.pscore_in;
    ds = (bus.dscore_in > 4'd9) ? 4'd9 : bus.dscore_in;
    // face cards, tens, empty and illegal codes all count as zero
    v = (bus.pcard3_in >= 4'd1 && bus.pcard3_in <= 4'd9) ? bus.pcard3_in : 4'd0;
    natural = ps >= 4'd8 || ds >= 4'd8;
    draw = ds <= 4'd2
        || (ds == 4'd3 && v != 4'd8)
        || (ds == 4'd4 && v >= 4'd2 && v <= 4'd7)
        || (ds == 4'd5 && v >= 4'd4 && v <= 4'd7)
        || (ds == 4'd6 && v >= 4'd6 && v <= 4'd7);
    nxt = START;
    case (state)
      START:   nxt = DEAL_P1;
      DEAL_P1: nxt = DEAL_D1;
      DEAL_D1: nxt = DEAL_P2;
      DEAL_P2: nxt = DEAL_D2;
      DEAL_D2: nxt = CHECK;
      CHECK:   nxt = natural ? DONE : ps <= 4'd5 ? DEAL_P3 : ds <= 4'd5 ? DEAL_D3 : DONE;
      DEAL_P3: nxt = BANKER;
      BANKER:  nxt = draw ? DEAL_D3 : DONE;
      DEAL_D3: nxt = DONE;
      DONE:    nxt = DONE;
      default: nxt = START;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset)
    if (reset) state <= START;
    else state <= nxt;

  assign bus.load_pcard1      = state == DEAL_P1;
  assign bus.load_dcard1      = state == DEAL_D1;
  assign bus.load_pcard2      = state == DEAL_P2;
  assign bus.load_dcard2      = state == DEAL_D2;
  assign bus.load_pcard3      = state == DEAL_P3;
  assign bus.load_dcard3      = state == DEAL_D3;
  assign bus.hand_done        = state == DONE;
  assign bus.player_win_light = state == DONE && ps >= ds;
  assign bus.dealer_win_light = state == DONE && ds >= ps;
  assign bus.state_out        = state;
endmodule

// File: tb/tb_baccarat_fsm.sv
// tb_baccarat_fsm: datapath model plus hand-level reference trace checked every cycle.
module tb_baccarat_fsm;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;

  baccarat_fsm_if bus ();
  baccarat_fsm dut (.slow_clock(clk), .reset(rst), .bus(bus));

  logic [3:0] deck [6];
  logic [3:0] pc [3];
  logic [3:0] dc [3];
  int n_cmp = 0, n_bad = 0;
  int k, n, idx, fp, fd, cnt_p3, cnt_d3;
  int ex_state [16];
  int ex_load [16];
  int ex_lt [16];
  logic [9:0] bank_mask [10] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
                                  10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
  logic [5:0] lv;

  function automatic int val(logic [3:0] c);
    return (c >= 1 && c <= 9) ? int'(c) : 0;
  endfunction

  assign bus.pscore_in = 4'((val(pc[0]) + val(pc[1]) + val(pc[2])) % 10);
  assign bus.dscore_in = 4'((val(dc[0]) + val(dc[1]) + val(dc[2])) % 10);
  assign bus.pcard3_in = pc[2];
  assign lv = {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
               bus.load_dcard1, bus.load_dcard2, bus.load_dcard3};

  always @(posedge clk or posedge rst)
    if (rst) begin
      pc[0] <= 0; pc[1] <= 0; pc[2] <= 0;
      dc[0] <= 0; dc[1] <= 0; dc[2] <= 0;
    end else begin
      if (bus.load_pcard1) pc[0] <= deck[0];
      if (bus.load_dcard1) dc[0] <= deck[1];
      if (bus.load_pcard2) pc[1] <= deck[2];
      if (bus.load_dcard2) dc[1] <= deck[3];
      if (bus.load_pcard3) pc[2] <= deck[4];
      if (bus.load_dcard3) dc[2] <= deck[5];
    end

  always @(posedge clk or posedge rst)
    k <= rst ? 0 : k + 1;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(int s, int l);
    ex_state[n] = s;
    ex_load[n]  = l;
    ex_lt[n]    = (s == 9) ? {30'd0, fp >= fd, fd >= fp} : 0;
    n++;
  endtask

  // Plays the hand from the deck by the table rules, listing what every cycle must show.
  task automatic build();
    int p, d, v;
    n = 0;
    p = (val(deck[0]) + val(deck[2])) % 10;
    d = (val(deck[1]) + val(deck[3])) % 10;
    add(0, 0); add(1, 6'b100000); add(2, 6'b000100);
    add(3, 6'b010000); add(4, 6'b000010); add(5, 0);
    if (!(p >= 8 || d >= 8)) begin
      if (p <= 5) begin
        add(6, 6'b001000);
        v = val(deck[4]);
        p = (p + v) % 10;
        add(7, 0);
        if (bank_mask[d][v]) begin
          add(8, 6'b000001);
          d = (d + val(deck[5])) % 10;
        end
      end else if (d <= 5) begin
        add(8, 6'b000001);
        d = (d + val(deck[5])) % 10;
      end
    end
    fp = p; fd = d;
    add(9, 0);
  endtask

  always @(negedge clk)
    if (!rst && n > 0) begin
      idx = k < n ? k : n - 1;
      check("state", int'(bus.state_out), ex_state[idx]);
      check("loads", int'(lv), ex_load[idx]);
      check("done", int'(bus.hand_done), int'(ex_state[idx] == 9));
      check("lights", int'({bus.player_win_light, bus.dealer_win_light}), ex_lt[idx]);
      if (bus.load_pcard3) cnt_p3++;
      if (bus.load_dcard3) cnt_d3++;
    end

  task automatic reset_check(string nm);
    rst = 1;
    #1;
    check({nm, "_state"}, int'(bus.state_out), 0);
    check({nm, "_outs"}, int'({lv, bus.player_win_light, bus.dealer_win_light, bus.hand_done}), 0);
  endtask

  task automatic start(int c0, int c1, int c2, int c3, int c4, int c5);
    deck[0] = 4'(c0); deck[1] = 4'(c1); deck[2] = 4'(c2);
    deck[3] = 4'(c3); deck[4] = 4'(c4); deck[5] = 4'(c5);
    build();
    @(negedge clk);
    #2;
    cnt_p3 = 0; cnt_d3 = 0;
    rst = 0;
  endtask

  task automatic run_hand(string nm, int c0, int c1, int c2, int c3, int c4, int c5,
                          int len, int pw, int dw, int p3, int d3);
    start(c0, c1, c2, c3, c4, c5);
    check({nm, "_model_len"}, n - 1, len);
    repeat (len + 3) @(posedge clk);
    #3;
    check({nm, "_state"}, int'(bus.state_out), 9);
    check({nm, "_done"}, int'(bus.hand_done), 1);
    check({nm, "_pwin"}, int'(bus.player_win_light), pw);
    check({nm, "_dwin"}, int'(bus.dealer_win_light), dw);
    check({nm, "_p3loads"}, cnt_p3, p3);
    check({nm, "_d3loads"}, cnt_d3, d3);
  endtask

  initial begin
    n = 0;
    #1;
    reset_check("por");
    run_hand("natural", 4, 3, 4, 13, 0, 0, 6, 1, 0, 0, 0);
    reset_check("rst_done1");
    start(2, 3, 2, 13, 8, 5);
    repeat (6) @(posedge clk);
    #2;
    check("abort_at_p3_state", int'(bus.state_out), 6);
    check("abort_at_p3_load", int'(bus.load_pcard3), 1);
    reset_check("rst_p3");
    run_hand("p_draw", 2, 3, 2, 13, 8, 5, 8, 0, 1, 1, 0);
    reset_check("rst_done2");
    run_hand("d_only", 3, 2, 4, 3, 0, 1, 7, 1, 0, 0, 1);
    reset_check("rst_done3");
    run_hand("tie", 1, 4, 5, 2, 12, 0, 6, 1, 1, 0, 0);
    reset_check("rst_done4");
    run_hand("both", 1, 13, 2, 2, 5, 4, 9, 1, 0, 1, 1);
    reset_check("rst_end");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
